// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state, beat constants and writeback bundle for memory_stage
package mem_stage_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int BEATS_V = 4;
  localparam int BEATS_S = 1;
  localparam int WORD_BYTES = 4;
  typedef struct packed {
    logic         valid;
    logic         wben;
    logic         vf;
    logic [3:0]   dest;
    logic [127:0] res;
  } wb_t;
endpackage

// File: rtl/mem_beat_sequencer.sv
// mem_beat_sequencer: beat index, beat address/write-data select and load assembly buffer
module mem_beat_sequencer
  import mem_stage_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int VW = 128,
  parameter int IW = $clog2(VW / DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          beat,
  input  logic [AW-1:0] addr_in,
  input  logic [VW-1:0] st_in,
  input  logic [DW-1:0] rdata,
  output logic [IW-1:0] idx,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic [VW-1:0] asm_data
);
  logic [AW-1:0] base;
  logic [VW-1:0] st_q;
  logic [VW-1:0] asm_q;
  // Capture word-aligned base and store operand on accept; advance one word per acked beat
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      base  <= '0;
      st_q  <= '0;
      asm_q <= '0;
      idx   <= '0;
    end else if (start) begin
      base  <= addr_in & ~AW'(WORD_BYTES - 1);
      st_q  <= st_in;
      asm_q <= '0;
      idx   <= '0;
    end else if (beat) begin
      asm_q <= asm_data;
      idx   <= idx + 1'b1;
    end
  assign addr  = base + AW'(idx) * AW'(WORD_BYTES);
  assign wdata = st_q[idx*DW +: DW];
  // Merge the word arriving this cycle so the final beat is visible without an extra cycle
  always_comb begin
    asm_data = asm_q;
    if (beat) asm_data[idx*DW +: DW] = rdata;
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: scalar/vector load-store stage over a 32-bit req/ack port with registered writeback
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int VW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          InValid,
  input  logic          MemRd,
  input  logic          MemWr,
  input  logic          VF,
  input  logic          WbEnIn,
  input  logic [3:0]    DestIn,
  input  logic [AW-1:0] Addr,
  input  logic [VW-1:0] StData,
  input  logic [VW-1:0] ResIn,
  output logic          Stall,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic          MemAck,
  input  logic [DW-1:0] MemRData,
  output logic          OutValid,
  output logic          WbEn,
  output logic          VFOut,
  output logic [3:0]    DestOut,
  output logic [VW-1:0] ResOut
);
  localparam int IW = $clog2(VW / DW);
  state_t        state;
  wb_t           wb;
  logic          st_q, vf_q, wben_q;
  logic [3:0]    dest_q;
  logic          access, accept, beat, last;
  logic [IW-1:0] idx;
  logic [AW-1:0] seq_addr;
  logic [DW-1:0] seq_wdata;
  logic [VW-1:0] asm_data;
  assign access   = state == ACCESS;
  assign accept   = state == IDLE && InValid && (MemRd || MemWr);
  assign beat     = access && MemAck;
  assign last     = beat && idx == (vf_q ? IW'(BEATS_V - 1) : IW'(BEATS_S - 1));
  assign Stall    = accept || (access && !last);
  assign MemReq   = access;
  assign MemWe    = access && st_q;
  assign MemAddr  = access ? seq_addr : '0;
  assign MemWData = access ? seq_wdata : '0;
  assign OutValid = wb.valid;
  assign WbEn     = wb.wben;
  assign VFOut    = wb.vf;
  assign DestOut  = wb.dest;
  assign ResOut   = wb.res;
  mem_beat_sequencer #(.AW(AW), .DW(DW), .VW(VW)) u_seq (
    .clk(clk), .rst(rst), .start(accept), .beat(beat), .addr_in(Addr), .st_in(StData),
    .rdata(MemRData), .idx(idx), .addr(seq_addr), .wdata(seq_wdata), .asm_data(asm_data)
  );
  // FSM and writeback register; a store (including rd+wr) never writes a register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      wb     <= '0;
      st_q   <= 1'b0;
      vf_q   <= 1'b0;
      wben_q <= 1'b0;
      dest_q <= '0;
    end else begin
      wb.valid <= 1'b0;
      if (accept) begin
        state  <= ACCESS;
        st_q   <= MemWr;
        vf_q   <= VF;
        wben_q <= WbEnIn;
        dest_q <= DestIn;
      end else if (state == IDLE && InValid) wb <= '{1'b1, WbEnIn, VF, DestIn, ResIn};
      else if (last) begin
        state <= IDLE;
        wb    <= '{1'b1, wben_q & ~st_q, vf_q, dest_q, st_q ? VW'(0) : asm_data};
      end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of ALU pass-through, scalar/vector load/store, wrap and reset abort
module tb_memory_stage;
  logic         clk = 0, rst = 0;
  logic         InValid = 0, MemRd = 0, MemWr = 0, VF = 0, WbEnIn = 0;
  logic [3:0]   DestIn = 0;
  logic [31:0]  Addr = 0;
  logic [127:0] StData = 0, ResIn = 0;
  logic         Stall, MemReq, MemWe, MemAck, OutValid, WbEn, VFOut;
  logic [31:0]  MemAddr, MemWData, MemRData;
  logic [3:0]   DestOut;
  logic [127:0] ResOut;
  logic [31:0]  mem [16];
  logic [3:0]   dly = 0, wcnt = 0;
  logic [31:0]  ba[$], bd[$];
  logic         bw[$];
  int           n_chk = 0, n_fail = 0, sc = 0;

  memory_stage dut (
    .clk(clk), .rst(rst), .InValid(InValid), .MemRd(MemRd), .MemWr(MemWr), .VF(VF),
    .WbEnIn(WbEnIn), .DestIn(DestIn), .Addr(Addr), .StData(StData), .ResIn(ResIn),
    .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData), .OutValid(OutValid), .WbEn(WbEn), .VFOut(VFOut),
    .DestOut(DestOut), .ResOut(ResOut)
  );

  always #5 clk = ~clk;

  assign MemAck   = MemReq && wcnt == dly;
  assign MemRData = mem[MemAddr[5:2]];

  // Memory responder: wait dly cycles per beat, log every completed beat
  always @(posedge clk) begin
    wcnt <= (!MemReq || MemAck) ? 4'd0 : wcnt + 4'd1;
    if (MemReq && MemAck) begin
      ba.push_back(MemAddr);
      bd.push_back(MemWData);
      bw.push_back(MemWe);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    ba.delete();
    bd.delete();
    bw.delete();
  endtask

  task automatic do_mem(input logic rd, wr, vf, we, input logic [3:0] d, input logic [31:0] a,
                        input logic [127:0] sd);
    InValid = 1; MemRd = rd; MemWr = wr; VF = vf; WbEnIn = we; DestIn = d; Addr = a;
    StData = sd; ResIn = '1;
    sc = 0;
    #1;
    while (Stall && sc < 60) begin
      @(negedge clk);
      sc++;
      #1;
    end
    if (Stall) check("stall_timeout", 1, 0);
    @(negedge clk);
    InValid = 0; MemRd = 0; MemWr = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    @(negedge clk);
    check("rst_outvalid", OutValid, 0);
    check("rst_resout", ResOut, 0);
    check("rst_memreq", {MemReq, MemWe, MemAddr, MemWData}, 0);
    check("rst_stall", Stall, 0);
    check("rst_wb", {WbEn, VFOut, DestOut}, 0);
    rst = 1;
    @(negedge clk);

    InValid = 1; ResIn = 128'h1111_2222_3333_4444_5555_6666_DEAD_BEEF; DestIn = 3; WbEnIn = 1;
    #1 check("alu_stall", Stall, 0);
    @(negedge clk);
    InValid = 0;
    check("alu_valid", OutValid, 1);
    check("alu_res", ResOut, 128'h1111_2222_3333_4444_5555_6666_DEAD_BEEF);
    check("alu_dest_wb", {DestOut, WbEn, VFOut}, {4'd3, 1'b1, 1'b0});
    @(negedge clk);
    check("idle_valid_drop", OutValid, 0);
    check("idle_res_hold", ResOut, 128'h1111_2222_3333_4444_5555_6666_DEAD_BEEF);

    mem[0] = 32'h1234_5678;
    mem[1] = 32'hFFFF_FFFF;
    clear_log();
    dly = 0;
    do_mem(1, 0, 0, 1, 4'd5, 32'h102, 128'h0);
    check("sload_stall_cycles", sc, 1);
    check("sload_beats", ba.size(), 1);
    check("sload_addr", ba[0], 32'h100);
    check("sload_valid", OutValid, 1);
    check("sload_res", ResOut, 128'h1234_5678);
    check("sload_wb", {DestOut, WbEn, VFOut}, {4'd5, 1'b1, 1'b0});

    clear_log();
    dly = 2;
    do_mem(0, 1, 1, 1, 4'd9, 32'hFFFF_FFF8, 128'h44444444_33333333_22222222_11111111);
    check("vst_stall_cycles", sc, 12);
    check("vst_beats", ba.size(), 4);
    check("vst_addr0", ba[0], 32'hFFFF_FFF8);
    check("vst_addr1", ba[1], 32'hFFFF_FFFC);
    check("vst_addr2", ba[2], 32'h0);
    check("vst_addr3", ba[3], 32'h4);
    check("vst_data", {bd[3], bd[2], bd[1], bd[0]}, 128'h44444444_33333333_22222222_11111111);
    check("vst_we", {bw[3], bw[2], bw[1], bw[0]}, 4'hF);
    check("vst_valid", OutValid, 1);
    check("vst_wb", {WbEn, VFOut, DestOut}, {1'b0, 1'b1, 4'd9});
    check("vst_res", ResOut, 0);

    mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC; mem[3] = 32'hD;
    clear_log();
    dly = 0;
    do_mem(1, 0, 1, 1, 4'd6, 32'h40, 128'h0);
    InValid = 1; ResIn = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677; DestIn = 7; WbEnIn = 0; VF = 0;
    check("vld_stall_cycles", sc, 4);
    check("vld_valid", OutValid, 1);
    check("vld_res", ResOut, 128'h0000000D_0000000C_0000000B_0000000A);
    check("vld_wb", {VFOut, WbEn, DestOut}, {1'b1, 1'b1, 4'd6});
    check("vld_we", {bw[3], bw[2], bw[1], bw[0]}, 4'h0);
    #1 check("b2b_stall", Stall, 0);
    @(negedge clk);
    InValid = 0;
    check("b2b_valid", OutValid, 1);
    check("b2b_res", ResOut, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    check("b2b_wb", {DestOut, WbEn, VFOut}, {4'd7, 1'b0, 1'b0});

    clear_log();
    dly = 0;
    InValid = 1; MemRd = 0; MemWr = 1; VF = 1; WbEnIn = 1; DestIn = 2; Addr = 32'h80;
    StData = 128'hDDDD0000_CCCC0000_BBBB0000_AAAA0000;
    @(negedge clk);
    InValid = 0; MemWr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("abort_memreq", {MemReq, MemAddr}, 0);
    check("abort_beats", ba.size(), 2);
    @(negedge clk);
    check("abort_held_req", MemReq, 0);
    rst = 1;
    @(negedge clk);
    check("abort_no_valid", OutValid, 0);
    check("abort_idle", {Stall, MemReq}, 0);
    check("abort_written", {bd[1], bd[0]}, 64'hBBBB0000_AAAA0000);

    clear_log();
    do_mem(1, 0, 0, 1, 4'd4, 32'h48, 128'h0);
    check("post_rst_load_valid", OutValid, 1);
    check("post_rst_load_res", ResOut, 128'hC);
    check("post_rst_load_addr", ba[0], 32'h48);

    clear_log();
    do_mem(1, 1, 0, 1, 4'd8, 32'h23, 128'h0000_55AA);
    check("rw_we", bw[0], 1);
    check("rw_addr_data", {ba[0], bd[0]}, {32'h20, 32'h55AA});
    check("rw_valid_wben", {OutValid, WbEn}, 2'b10);
    check("rw_res", ResOut, 0);

    @(negedge clk);
    check("final_quiet", {OutValid, MemReq, Stall}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
